// File: rtl/seq_pattern_pkg.sv
// Shared state encoding, default pattern and counter sizing for seq_pattern_gen.
package seq_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_e;

    localparam logic [3:0] SEQ_DEFAULT_PATTERN = 4'b1010;

    // Width of a down-counter that holds values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_pattern_shifter.sv
// Parallel-load MSB-first shift register holding the bits that follow the one on the line.
// last_o rises once the bit currently on the line is the pattern's LSB.
module seq_pattern_shifter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-2:0] tail_i,
    output logic         next_o,
    output logic         last_o
);

    logic [W-2:0] sr_q;
    logic [W-2:0] mask_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and active-low; it is only seen at a rising edge.
        if (!reset) begin
            sr_q   <= '0;
            mask_q <= '0;
        end else if (load_i) begin
            sr_q   <= tail_i;
            mask_q <= '1;
        end else if (shift_i) begin
            sr_q   <= sr_q << 1;
            mask_q <= mask_q << 1;
        end
    end

    // A one drains out of the mask per shift; when it is empty no bits remain.
    assign next_o = sr_q[W-2];
    assign last_o = ~mask_q[W-2];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: MSB-first, R repetitions separated by GAP_CYCLES idle cycles.
// Define SEQ_PATTERN_GEN_PARITY_EN to append an even-parity bit after every pattern.
module seq_pattern_gen
    import seq_pattern_pkg::*;
#(
    parameter int                   PATTERN_W       = 4,
    parameter int                   REP_W           = 4,
    parameter int                   GAP_CYCLES      = 2,
    parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = PATTERN_W'(SEQ_DEFAULT_PATTERN)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 use_default,
    input  logic [PATTERN_W-1:0] pattern_in,
    input  logic [REP_W-1:0]     repeat_cnt,
    output logic                 x,
    output logic                 x_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int GAP_W = cnt_width(GAP_CYCLES);

    state_e               state_q, state_d;
    logic [PATTERN_W-1:0] pat_q, pat_d;
    logic [PATTERN_W-1:0] sel_pat;
    logic [REP_W-1:0]     rep_q, rep_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic                 x_q, x_d;
    logic                 x_valid_q, x_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 sh_load, sh_shift, sh_next, sh_last;
    logic [PATTERN_W-2:0] sh_tail;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    logic                 par_phase_q, par_phase_d;
`endif

    assign sel_pat = use_default ? DEFAULT_PATTERN : pattern_in;

    seq_pattern_shifter #(.W(PATTERN_W)) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .tail_i  (sh_tail),
        .next_o  (sh_next),
        .last_o  (sh_last)
    );

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        x_d       = 1'b0;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_tail   = pat_q[PATTERN_W-2:0];
`ifdef SEQ_PATTERN_GEN_PARITY_EN
        par_phase_d = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d     = sel_pat;
                    rep_d     = (repeat_cnt == '0) ? REP_W'(1) : repeat_cnt;
                    sh_load   = 1'b1;
                    sh_tail   = sel_pat[PATTERN_W-2:0];
                    x_d       = sel_pat[PATTERN_W-1];
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                busy_d = 1'b1;
                if (!sh_last) begin
                    sh_shift  = 1'b1;
                    x_d       = sh_next;
                    x_valid_d = 1'b1;
                end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
                else if (!par_phase_q) begin
                    par_phase_d = 1'b1;
                    x_d         = ^pat_q;
                    x_valid_d   = 1'b1;
                end
`endif
                else if (rep_q > REP_W'(1)) begin
                    rep_d = rep_q - REP_W'(1);
                    if (GAP_CYCLES > 0) begin
                        gap_d   = GAP_W'(GAP_CYCLES - 1);
                        state_d = GAP;
                    end else begin
                        sh_load   = 1'b1;
                        x_d       = pat_q[PATTERN_W-1];
                        x_valid_d = 1'b1;
                    end
                end else begin
                    rep_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            GAP: begin
                busy_d = 1'b1;
                if (gap_q == '0) begin
                    sh_load   = 1'b1;
                    x_d       = pat_q[PATTERN_W-1];
                    x_valid_d = 1'b1;
                    state_d   = SHIFT;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

            DONE: begin
                // start is deliberately not looked at here; it is taken in IDLE next cycle.
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
            par_phase_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
            par_phase_q <= par_phase_d;
`endif
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: per-cycle expected {x,x_valid,busy,done} kept in a scoreboard queue.
module tb_seq_pattern_gen;

    localparam int             PW  = 4;
    localparam int             RW  = 4;
    localparam int             GAP = 2;
    localparam logic [PW-1:0]  DEF = 4'b1010;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          use_default;
    logic [PW-1:0] pattern_in;
    logic [RW-1:0] repeat_cnt;
    logic          x, x_valid, busy, done;

    int         tests = 0;
    int         fails = 0;
    logic [3:0] exp_q[$];

    seq_pattern_gen #(
        .PATTERN_W       (PW),
        .REP_W           (RW),
        .GAP_CYCLES      (GAP),
        .DEFAULT_PATTERN (DEF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .use_default (use_default),
        .pattern_in  (pattern_in),
        .repeat_cnt  (repeat_cnt),
        .x           (x),
        .x_valid     (x_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed {x,x_valid,busy,done}=%b expected %b", tag, obs, expv);
        end
    endtask

    // Expected line activity of one transmission, cycle by cycle, ending with done and one idle cycle.
    function automatic void push_txn(input logic [PW-1:0] pat, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = PW - 1; i >= 0; i--) exp_q.push_back({pat[i], 3'b110});
`ifdef SEQ_PATTERN_GEN_PARITY_EN
            exp_q.push_back({^pat, 3'b110});
`endif
            if (r < reps - 1)
                for (int g = 0; g < GAP; g++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
    endfunction

    // Called at a negedge with the DUT idle. poke_at: observed-cycle index after which start is
    // pulsed and pattern_in/repeat_cnt disturbed. reset_at: index after which reset aborts the run.
    task automatic send(input string name, input logic use_def, input logic [PW-1:0] pat,
                        input logic [RW-1:0] rep, input int poke_at, input logic [PW-1:0] poke_pat,
                        input int reset_at);
        int idx;
        push_txn(use_def ? DEF : pat, (rep == '0) ? 1 : int'(rep));
        use_default = use_def;
        pattern_in  = pat;
        repeat_cnt  = rep;
        start       = 1'b1;
        idx         = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("%s[%0d]", name, idx), {x, x_valid, busy, done}, exp_q.pop_front());
            if (idx == poke_at) begin
                start      = 1'b1;
                pattern_in = poke_pat;
                repeat_cnt = rep + RW'(1);
            end
            if (idx == reset_at) begin
                reset = 1'b0;
                exp_q.delete();
            end
            idx++;
        end
        if (reset_at >= 0) begin
            @(negedge clk);
            check({name, "_abort"}, {x, x_valid, busy, done}, 4'b0000);
            reset = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check($sformatf("%s_post_reset[%0d]", name, k), {x, x_valid, busy, done}, 4'b0000);
            end
        end
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b1;
        use_default = 1'b0;
        pattern_in  = 4'b1111;
        repeat_cnt  = 4'd2;

        // start held during reset must have no effect.
        @(negedge clk);
        check("reset0", {x, x_valid, busy, done}, 4'b0000);
        @(negedge clk);
        check("reset1", {x, x_valid, busy, done}, 4'b0000);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {x, x_valid, busy, done}, 4'b0000);

        send("default_r1", 1'b1, 4'b0000, 4'd1, -1, 4'b0000, -1);
        send("p0110_r3",   1'b0, 4'b0110, 4'd3, -1, 4'b0000, -1);
        send("rep_zero",   1'b0, 4'b1101, 4'd0, -1, 4'b0000, -1);
        send("mid_start",  1'b0, 4'b1001, 4'd2,  1, 4'b0110, -1);
        // Start raised in the DONE cycle (index 4) must be ignored.
        send("start_in_done", 1'b0, 4'b0101, 4'd1, 4, 4'b1111, -1);
        send("after_done", 1'b0, 4'b1100, 4'd1, -1, 4'b0000, -1);
        send("reset_mid",  1'b0, 4'b1011, 4'd2, -1, 4'b0000, 1);
        send("fresh",      1'b0, 4'b1011, 4'd1, -1, 4'b0000, -1);
        send("p1010",      1'b0, 4'b1010, 4'd1, -1, 4'b0000, -1);
        send("p0001_r2",   1'b0, 4'b0001, 4'd2, -1, 4'b0000, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
